vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 103 ++++++++++
 tb/tb_vga_timing.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator (counters, syncs, blank, frame tracking)
//
// Purpose: free-running horizontal/vertical raster counters with registered
// sync, blank and frame-start outputs that all describe the pixel currently
// shown on DrawX/DrawY.
//
// Ports:
//   vga_clk     in   pixel clock, all state changes on its rising edge
//   Reset       in   asynchronous active-high reset
//   hs          out  horizontal sync, active low
//   vs          out  vertical sync, active low
//   blank       out  display enable, 1 = visible pixel
//   DrawX       out  [9:0] horizontal pixel counter
//   DrawY       out  [9:0] vertical line counter
//   frame_start out  one-cycle pulse at (0,0) reached by wrap-around
//   frame_count out  [15:0] completed frames since reset, wraps mod 2^16

module vga_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        vga_clk,
  input  logic        Reset,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        h_wrap;
  logic        v_wrap;

  // Decoded outputs are derived from the next-state counters so that, once
  // registered, they line up with the counter registers in the same cycle.
  always_comb begin
    h_wrap        = (hc_q == 10'(H_TOT - 1));
    v_wrap        = (vc_q == 10'(V_TOT - 1));
    hc_d          = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d          = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
    end
    hs_d          = !((int'(hc_d) >= HS_START) && (int'(hc_d) <= HS_END));
    vs_d          = !((int'(vc_d) >= VS_START) && (int'(vc_d) <= VS_END));
    blank_d       = (int'(hc_d) < H_VIS) && (int'(vc_d) < V_VIS);
    // Only a genuine wrap of both counters starts a frame; the reset state
    // (0,0) never produces a pulse.
    frame_start_d = h_wrap && v_wrap;
    frame_count_d = frame_count_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing (small, default and 1x1 raster builds)

module tb_vga_timing;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_w;

  always #5 clk = ~clk;

  // Small raster: 15 x 8, frame of 120 cycles.
  logic hs_s, vs_s, bl_s, fs_s;
  logic [9:0] x_s, y_s;
  logic [15:0] fc_s;
  vga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .vga_clk(clk), .Reset(rst_a), .hs(hs_s), .vs(vs_s), .blank(bl_s),
    .DrawX(x_s), .DrawY(y_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  // Default 800 x 525 raster, line-level behaviour only within the run.
  logic hs_d, vs_d, bl_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [15:0] fc_d;
  vga_timing dut_d (
    .vga_clk(clk), .Reset(rst_a), .hs(hs_d), .vs(vs_d), .blank(bl_d),
    .DrawX(x_d), .DrawY(y_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  // 1 x 1 raster: one frame per cycle, exercises the frame_count wrap.
  logic hs_w, vs_w, bl_w, fs_w;
  logic [9:0] x_w, y_w;
  logic [15:0] fc_w;
  vga_timing #(
    .H_VIS(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_VIS(1), .V_FP(0), .V_SYNC(0), .V_BP(0)
  ) dut_w (
    .vga_clk(clk), .Reset(rst_w), .hs(hs_w), .vs(vs_w), .blank(bl_w),
    .DrawX(x_w), .DrawY(y_w), .frame_start(fs_w), .frame_count(fc_w)
  );

  obs_t q_s[$];
  obs_t q_d[$];
  obs_t q_w[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  // Reference: everything follows from the number of counted edges t since reset.
  function automatic obs_t model(longint t, int hv, int hfp, int hsy, int hbp,
                                 int vv, int vfp, int vsy, int vbp);
    obs_t   o;
    longint ht, vt, hc, vc, fr;
    ht = hv + hfp + hsy + hbp;
    vt = vv + vfp + vsy + vbp;
    hc = t % ht;
    vc = (t / ht) % vt;
    fr = t / (ht * vt);
    o.hs    = !((hc >= hv + hfp) && (hc < hv + hfp + hsy));
    o.vs    = !((vc >= vv + vfp) && (vc < vv + vfp + vsy));
    o.blank = (hc < hv) && (vc < vv);
    o.x     = 10'(hc);
    o.y     = 10'(vc);
    o.fs    = (t > 0) && ((t % (ht * vt)) == 0);
    o.fc    = 16'(fr % 65536);
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t act hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d exp hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d",
               name, $time, act.hs, act.vs, act.blank, act.x, act.y, act.fs, act.fc,
               exp.hs, exp.vs, exp.blank, exp.x, exp.y, exp.fs, exp.fc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        check("small", {hs_s, vs_s, bl_s, x_s, y_s, fs_s, fc_s}, e);
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        check("default", {hs_d, vs_d, bl_d, x_d, y_d, fs_d, fc_d}, e);
      end
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        check("wrap", {hs_w, vs_w, bl_w, x_w, y_w, fs_w, fc_w}, e);
      end
    end
  end

  // Stimulus: drives resets 2 time units after each rising edge, so reset
  // assertion is asynchronous to the clock, then pushes the expected view.
  initial begin
    longint t_a = 0;
    longint t_w = 0;
    int     hold = 0;
    bit     targeted = 1'b0;
    rst_a = 1'b1;
    rst_w = 1'b1;
    for (int cyc = 0; cyc < 65600; cyc++) begin
      @(posedge clk);
      if (!rst_a) t_a++;
      if (!rst_w) t_w++;
      #2;
      if (cyc == 0) rst_w = 1'b0;
      if (rst_a) begin
        if (hold == 0) rst_a = 1'b0;
        else hold--;
      end else if (!targeted && cyc >= 1700 && t_a == 101) begin
        // Small raster at x=11, y=6: inside both hsync and vsync pulses.
        rst_a    = 1'b1;
        hold     = $urandom_range(0, 2);
        targeted = 1'b1;
      end else if (targeted && $urandom_range(0, 1499) == 0) begin
        rst_a = 1'b1;
        hold  = $urandom_range(0, 2);
      end
      if (rst_a) t_a = 0;
      if (rst_w) t_w = 0;
      q_s.push_back(model(t_a, 8, 2, 3, 2, 4, 1, 2, 1));
      q_d.push_back(model(t_a, 640, 16, 96, 48, 480, 10, 2, 33));
      q_w.push_back(model(t_w, 1, 0, 0, 0, 1, 0, 0, 0));
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    n_cmp++;
    if (q_s.size() + q_d.size() + q_w.size() != 0) begin
      n_fail++;
      $display("FAIL drain act=%0d pending required=0", q_s.size() + q_d.size() + q_w.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
